// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one external ALU: grant, issue register, per-port response slot.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int CONT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [CONT_W-1:0] req_cont0,
    input  logic [CONT_W-1:0] req_cont1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic              rsp_zero0,
    output logic              rsp_zero1,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [CONT_W-1:0] alu_cont,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is combinational from req_valid and state; requesters hold valid independently.
    logic              iss_valid_q, iss_valid_d;
    logic              iss_owner_q, iss_owner_d;
    logic [DATA_W-1:0] iss_a_q, iss_a_d;
    logic [DATA_W-1:0] iss_b_q, iss_b_d;
    logic [CONT_W-1:0] iss_cont_q, iss_cont_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
    logic              rsp_zero0_q, rsp_zero0_d;
    logic              rsp_zero1_q, rsp_zero1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    logic [1:0] elig;
    logic [1:0] grant;
    logic [1:0] wb;

    always_comb begin
        wb[0] = iss_valid_q && !iss_owner_q;
        wb[1] = iss_valid_q && iss_owner_q;
        elig[0] = req_valid[0] && !wb[0] && (!rsp_valid_q[0] || rsp_ready[0]);
        elig[1] = req_valid[1] && !wb[1] && (!rsp_valid_q[1] || rsp_ready[1]);

        grant = 2'b00;
        if (rst_n) begin
            if (elig == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_q ? 2'b01 : 2'b10;
`endif
            end else begin
                grant = elig;
            end
        end
    end

    always_comb begin
        iss_valid_d = |grant;
        iss_owner_d = iss_owner_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_cont_d  = iss_cont_q;
        if (grant[0]) begin
            iss_owner_d = 1'b0;
            iss_a_d     = req_a0;
            iss_b_d     = req_b0;
            iss_cont_d  = req_cont0;
        end else if (grant[1]) begin
            iss_owner_d = 1'b1;
            iss_a_d     = req_a1;
            iss_b_d     = req_b1;
            iss_cont_d  = req_cont1;
        end

        // A writeback landing in the same cycle as a handshake overwrites the slot and keeps it valid.
        rsp_valid_d = wb | (rsp_valid_q & ~rsp_ready);
        rsp_data0_d = wb[0] ? alu_result : rsp_data0_q;
        rsp_zero0_d = wb[0] ? alu_zero   : rsp_zero0_q;
        rsp_data1_d = wb[1] ? alu_result : rsp_data1_q;
        rsp_zero1_d = wb[1] ? alu_zero   : rsp_zero1_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d = (|grant) ? grant[1] : last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_owner_q <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_cont_q  <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
            rsp_zero0_q <= 1'b0;
            rsp_zero1_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_owner_q <= iss_owner_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_cont_q  <= iss_cont_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_zero0_q <= rsp_zero0_d;
            rsp_zero1_q <= rsp_zero1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data0 = rsp_data0_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_zero0 = rsp_zero0_q;
    assign rsp_zero1 = rsp_zero1_q;
    assign alu_in_a  = iss_a_q;
    assign alu_in_b  = iss_b_q;
    assign alu_cont  = iss_cont_q;

endmodule
